nonce_sched: RTL and testbench
==============================

# nonce_sched

Job scheduler for the nonce-generation front end of the miner. It accepts one 80-byte block-header job plus a total nonce range from the host side. It splits the range evenly across `NUM_GEN` nonce-generator instances, then loads and starts each generator with its own base nonce and slice size. It detects job completion, and sequences abort through the generators' stop/stop-acknowledge handshake.

## Interface
- `NUM_GEN`, 4: number of generator instances; power of two, 1..16.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `job_valid` in 1: host header word valid.
- `job_ready` out 1: scheduler accepts a header word.
- `job_word` in 32: header word; word 0 is the base-nonce field, words 1..19 follow.
- `job_range` in 32: total nonce count; sampled with word 0.
- `abort` in 1: single-cycle request to cancel the current job.
- `gen_start` out NUM_GEN: one-cycle start pulse per generator.
- `gen_stop` out NUM_GEN: level stop request per generator.
- `gen_stop_ack` in NUM_GEN: generator idle / ready for start.
- `gen_hdr` out 32: header word broadcast to the generators.
- `gen_hdr_we` out NUM_GEN: one-hot header write enable.
- `gen_nonce_size` out 32: slice size for the generator being loaded.
- `busy` out 1: state is not IDLE.
- `job_done` out 1: one-cycle pulse when a job completes normally.
- `job_aborted` out 1: one-cycle pulse when abort completes.
- `job_count` out 32: number of completed (not aborted) jobs; wraps.

## Operation
- States: IDLE, CAPTURE, WAIT_IDLE, START, LOAD, GAP, RUN, STOP.
- IDLE:
  - `job_ready`=1.
  - On the first accepted word (`job_valid & job_ready`), store word 0, latch `job_range`, and go to CAPTURE.
- CAPTURE:
  - `job_ready`=1 until 20 words are stored in the 20x32 buffer.
  - If `job_range`==0: pulse `job_done`, increment `job_count`, go to IDLE. No generator is touched.
  - Otherwise go to WAIT_IDLE.
- Slice arithmetic:
  - `slice = job_range >> log2(NUM_GEN)`.
  - The last generator gets `job_range - slice*(NUM_GEN-1)`.
  - `base_g = word0 + g*slice`, computed modulo 2^32 (wraps).
  - A slice of 0 is legal.
- WAIT_IDLE: wait until all `gen_stop_ack` bits are 1, then go to START.
- START: `gen_start` = all ones for exactly one cycle; clear `ack_low_seen` mask; go to LOAD with g=0.
- LOAD:
  - For generator g, words 0..19 are driven on consecutive cycles with `gen_hdr_we[g]`=1.
  - Word 0 is replaced by `base_g`.
  - `gen_nonce_size` = slice_g.
  - There is no backpressure.
- GAP:
  - One cycle after word 19; `gen_nonce_size` is held at slice_g while the generator samples it.
  - Then either g+1 goes to LOAD, or, after the last generator, go to RUN.
- `ack_low_seen[g]` sets whenever `gen_stop_ack[g]`=0 after START.
- RUN:
  - When `ack_low_seen` is all ones and `gen_stop_ack` is all ones: pulse `job_done`, increment `job_count`, go to IDLE.
- Abort:
  - Abort in IDLE: ignored.
  - Abort in CAPTURE: discard the buffer, pulse `job_aborted`, go to IDLE.
  - Abort in WAIT_IDLE, START, LOAD or GAP: latched in `abort_pend`. Loading always finishes, because an unloaded generator would wait forever for header words.
  - Abort in RUN, or on entry to RUN with `abort_pend`: go to STOP.
- STOP:
  - `gen_stop` = all ones until all `gen_stop_ack` bits are 1 and `ack_low_seen` is all ones.
  - Then pulse `job_aborted`, clear `abort_pend`, go to IDLE.
  - `job_count` is unchanged.

## Timing
- Reset values:
  - `job_ready` 0 during reset, 1 the cycle after.
  - `gen_start`, `gen_stop`, `gen_hdr_we`: 0.
  - `gen_hdr`, `gen_nonce_size`: 0.
  - `busy`, `job_done`, `job_aborted`: 0.
  - `job_count`: 0.
  - State IDLE; `abort_pend` 0.
- Reset mid-operation: all outputs return to their reset values in the next cycle. Generators are not stopped by this block; the system reset covers them.
- All outputs are registered.
- The first `gen_hdr_we` occurs in the cycle after the `gen_start` pulse.
- Load latency: exactly 21*NUM_GEN cycles from the first `gen_hdr_we` to RUN entry.
- Minimum job overhead: 20 capture cycles + 1 (WAIT_IDLE, if generators are idle) + 1 (START) + 21*NUM_GEN.
- `job_done` / `job_aborted`: asserted in the cycle after the completion condition is observed; high for one cycle only.
- Simultaneous events:
  - Abort in the same cycle as the RUN completion condition: completion wins (`job_done`, no `job_aborted`).
  - Abort while in STOP: no effect.

## Configuration
- `NONCE_SCHED_PERF_EN`:
  - When defined, adds output `run_cycles` (32 bits). It counts cycles spent in LOAD, GAP, RUN and STOP for the current job. It clears at START and holds its value in IDLE. Reset value 0.
  - When undefined, the port and counter are absent; behaviour is otherwise identical.

## Test plan
All scenarios use `NUM_GEN`=4.
- Basic split: base 0x00000100, range 0x1000.
  - Required bases: 0x100, 0x500, 0x900, 0xD00.
  - Required sizes: 0x400 each.
  - After generators ack, `job_done` pulses once and `job_count`=1.
- Remainder: range 0x1003.
  - Sizes 0x400, 0x400, 0x400, 0x403.
  - Word 0 replacement on each generator; words 1..19 are identical to the captured ones.
- Wrap: base 0xFFFFFF00, range 0x400.
  - Bases 0xFFFFFF00, 0x00000000, 0x00000100, 0x00000200.
- Abort during LOAD (generator 1, word 5):
  - Loading of generators 1..3 completes.
  - `gen_stop` rises on RUN entry and stays high until all acks are 1.
  - `job_aborted` pulses; `job_count` is unchanged.
- Zero range and reset:
  - Range 0: `job_done` pulses right after capture with no `gen_start`.
  - `rst` asserted mid-LOAD: all outputs return to 0 and state to IDLE the next cycle; `job_ready`=1 the cycle after `rst` deasserts.

Source files
------------

// File: rtl/nonce_sched_if.sv
// Host-job and generator-control bundle for nonce_sched.
// master: host/generator side (drives job words, abort, stop acks).
// slave:  the scheduler itself.
interface nonce_sched_if #(
    parameter int unsigned NUM_GEN = 4
);
    logic               job_valid;
    logic               job_ready;
    logic [31:0]        job_word;
    logic [31:0]        job_range;
    logic               abort;
    logic [NUM_GEN-1:0] gen_start;
    logic [NUM_GEN-1:0] gen_stop;
    logic [NUM_GEN-1:0] gen_stop_ack;
    logic [31:0]        gen_hdr;
    logic [NUM_GEN-1:0] gen_hdr_we;
    logic [31:0]        gen_nonce_size;
    logic               busy;
    logic               job_done;
    logic               job_aborted;
    logic [31:0]        job_count;

    modport master (
        output job_valid, job_word, job_range, abort, gen_stop_ack,
        input  job_ready, gen_start, gen_stop, gen_hdr, gen_hdr_we, gen_nonce_size,
        input  busy, job_done, job_aborted, job_count
    );

    modport slave (
        input  job_valid, job_word, job_range, abort, gen_stop_ack,
        output job_ready, gen_start, gen_stop, gen_hdr, gen_hdr_we, gen_nonce_size,
        output busy, job_done, job_aborted, job_count
    );
endinterface

// File: rtl/nonce_sched.sv
// Nonce-range job scheduler: captures a 20-word header job, splits the nonce range
// across NUM_GEN generators, loads/starts them, and tracks completion or abort.
// Optional feature macro: NONCE_SCHED_PERF_EN adds the run_cycles counter output.
module nonce_sched #(
    parameter int unsigned NUM_GEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    nonce_sched_if.slave bus
`ifdef NONCE_SCHED_PERF_EN
    ,
    output logic [31:0] run_cycles
`endif
);
    localparam int unsigned LOG_GEN = $clog2(NUM_GEN);
    localparam int unsigned GW = (NUM_GEN > 1) ? LOG_GEN : 1;
    localparam logic [GW-1:0] LAST_GEN = GW'(NUM_GEN - 1);
    localparam logic [4:0] NUM_WORDS = 5'd20;
    localparam logic [4:0] LAST_WORD = 5'd19;

    typedef enum logic [2:0] {
        StIdle, StCapture, StWaitIdle, StStart, StLoad, StGap, StRun, StStop
    } state_e;

    state_e state_q, state_d;
    logic [4:0]         wcnt_q, wcnt_d;
    logic [GW-1:0]      gidx_q, gidx_d;
    logic [4:0]         widx_q, widx_d;
    logic [31:0]        base_q, base_d;
    logic [31:0]        range_q, range_d;
    logic               abort_pend_q, abort_pend_d;
    logic [NUM_GEN-1:0] ack_low_q, ack_low_d;
    logic [31:0]        count_q, count_d;

    logic               job_ready_q, job_ready_d;
    logic [NUM_GEN-1:0] gen_start_q, gen_start_d;
    logic [NUM_GEN-1:0] gen_stop_q, gen_stop_d;
    logic [NUM_GEN-1:0] gen_hdr_we_q, gen_hdr_we_d;
    logic [31:0]        gen_hdr_q, gen_hdr_d;
    logic [31:0]        gen_size_q, gen_size_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic [31:0] hdr_buf [20];
    logic        buf_we;
    logic [4:0]  buf_addr;

    logic [31:0] slice;
    logic [31:0] last_slice;
    logic        ack_all;
    logic        ack_low_all;
    logic        accept;

    assign slice       = range_q >> LOG_GEN;
    // Last generator absorbs the remainder left by the shift.
    assign last_slice  = range_q - slice * 32'(NUM_GEN - 1);
    assign ack_all     = &bus.gen_stop_ack;
    assign ack_low_all = &ack_low_q;
    assign accept      = bus.job_valid & job_ready_q;

    // Next-state, bookkeeping and registered-output decode.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        gidx_d       = gidx_q;
        widx_d       = widx_q;
        base_d       = base_q;
        range_d      = range_q;
        abort_pend_d = abort_pend_q;
        count_d      = count_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        buf_we       = 1'b0;
        buf_addr     = wcnt_q;
        // A generator must be seen busy after START before its ack counts as done.
        ack_low_d    = (state_q == StStart) ? '0 : (ack_low_q | ~bus.gen_stop_ack);

        unique case (state_q)
            StIdle: begin
                abort_pend_d = 1'b0;
                if (accept) begin
                    buf_we   = 1'b1;
                    buf_addr = 5'd0;
                    wcnt_d   = 5'd1;
                    range_d  = bus.job_range;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else if (wcnt_q == NUM_WORDS) begin
                    if (range_q == 32'd0) begin
                        done_d  = 1'b1;
                        count_d = count_q + 32'd1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitIdle;
                    end
                end else if (accept) begin
                    buf_we = 1'b1;
                    wcnt_d = wcnt_q + 5'd1;
                end
            end
            StWaitIdle: begin
                if (bus.abort) abort_pend_d = 1'b1;
                if (ack_all) state_d = StStart;
            end
            StStart: begin
                if (bus.abort) abort_pend_d = 1'b1;
                gidx_d  = '0;
                widx_d  = 5'd0;
                base_d  = hdr_buf[0];
                state_d = StLoad;
            end
            StLoad: begin
                if (bus.abort) abort_pend_d = 1'b1;
                if (widx_q == LAST_WORD) begin
                    state_d = StGap;
                end else begin
                    widx_d = widx_q + 5'd1;
                end
            end
            StGap: begin
                if (bus.abort) abort_pend_d = 1'b1;
                if (gidx_q == LAST_GEN) begin
                    // A pending abort skips RUN so stop is raised as soon as loading ends.
                    state_d = (abort_pend_q || bus.abort) ? StStop : StRun;
                end else begin
                    gidx_d  = gidx_q + GW'(1);
                    widx_d  = 5'd0;
                    base_d  = base_q + slice;
                    state_d = StLoad;
                end
            end
            StRun: begin
                // Completion takes priority over a same-cycle abort.
                if (ack_low_all && ack_all) begin
                    done_d  = 1'b1;
                    count_d = count_q + 32'd1;
                    state_d = StIdle;
                end else if (bus.abort || abort_pend_q) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (ack_low_all && ack_all) begin
                    aborted_d    = 1'b1;
                    abort_pend_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        job_ready_d  = (state_d == StIdle) || ((state_d == StCapture) && (wcnt_d < NUM_WORDS));
        busy_d       = (state_d != StIdle);
        gen_start_d  = {NUM_GEN{state_d == StStart}};
        gen_stop_d   = {NUM_GEN{state_d == StStop}};
        gen_hdr_we_d = '0;
        gen_hdr_d    = 32'd0;
        gen_size_d   = 32'd0;
        if (state_d == StLoad) begin
            gen_hdr_we_d = NUM_GEN'(1) << gidx_d;
            gen_hdr_d    = (widx_d == 5'd0) ? base_d : hdr_buf[widx_d];
        end
        if (state_d == StLoad || state_d == StGap) begin
            gen_size_d = (gidx_d == LAST_GEN) ? last_slice : slice;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wcnt_q       <= 5'd0;
            gidx_q       <= '0;
            widx_q       <= 5'd0;
            base_q       <= 32'd0;
            range_q      <= 32'd0;
            abort_pend_q <= 1'b0;
            ack_low_q    <= '0;
            count_q      <= 32'd0;
            job_ready_q  <= 1'b0;
            gen_start_q  <= '0;
            gen_stop_q   <= '0;
            gen_hdr_we_q <= '0;
            gen_hdr_q    <= 32'd0;
            gen_size_q   <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            gidx_q       <= gidx_d;
            widx_q       <= widx_d;
            base_q       <= base_d;
            range_q      <= range_d;
            abort_pend_q <= abort_pend_d;
            ack_low_q    <= ack_low_d;
            count_q      <= count_d;
            job_ready_q  <= job_ready_d;
            gen_start_q  <= gen_start_d;
            gen_stop_q   <= gen_stop_d;
            gen_hdr_we_q <= gen_hdr_we_d;
            gen_hdr_q    <= gen_hdr_d;
            gen_size_q   <= gen_size_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Header buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we) hdr_buf[buf_addr] <= bus.job_word;
    end

`ifdef NONCE_SCHED_PERF_EN
    logic [31:0] run_cycles_q;

    // Cycles spent loading, running and stopping the current job.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles_q <= 32'd0;
        end else if (state_q == StStart) begin
            run_cycles_q <= 32'd0;
        end else if (state_q == StLoad || state_q == StGap ||
                     state_q == StRun || state_q == StStop) begin
            run_cycles_q <= run_cycles_q + 32'd1;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

    assign bus.job_ready      = job_ready_q;
    assign bus.gen_start      = gen_start_q;
    assign bus.gen_stop       = gen_stop_q;
    assign bus.gen_hdr        = gen_hdr_q;
    assign bus.gen_hdr_we     = gen_hdr_we_q;
    assign bus.gen_nonce_size = gen_size_q;
    assign bus.busy           = busy_q;
    assign bus.job_done       = done_q;
    assign bus.job_aborted    = aborted_q;
    assign bus.job_count      = count_q;
endmodule

// File: tb/tb_nonce_sched.sv
// Self-checking bench for nonce_sched with NUM_GEN=4: behavioural generator model,
// monitor recording per-generator loads, and scenario tasks checked against
// slice/base values computed directly from the range-splitting rules.
module tb_nonce_sched;
    localparam int NG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nonce_sched_if #(.NUM_GEN(NG)) bus ();

`ifdef NONCE_SCHED_PERF_EN
    logic [31:0] run_cycles;
    nonce_sched #(.NUM_GEN(NG)) dut (.clk(clk), .rst(rst), .bus(bus), .run_cycles(run_cycles));
`else
    nonce_sched #(.NUM_GEN(NG)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] hdr_ref [20];
    logic [31:0] rec_hdr [NG][20];
    logic [31:0] rec_size [NG];
    int rec_n [NG];
    int start_cyc = 0, start_cnt = 0, start_err = 0;
    int done_cnt = 0, done_cyc = 0, abt_cnt = 0, abt_cyc = 0;
    int timing_err = 0, size_err = 0, gap_err = 0, we_err = 0;
    int stop_rise_cyc = 0, stop_fall_cnt = 0, stop_fall_bad = 0, ack_rise_cyc = 0;
    logic prev_stop = 1'b0, prev_all = 1'b0;

    // Generator model state
    bit gbusy [NG];
    int gwords [NG];
    int grun [NG];
    int gstop [NG];
    int pre_until [NG];
    int run_len = 5;
    bit hold = 1'b0;

    // Generator model: busy from start until its run finishes or stop is honoured.
    always @(posedge clk) begin
        logic [NG-1:0] v;
        #2;
        for (int g = 0; g < NG; g++) begin
            if (rst) begin
                gbusy[g] = 1'b0; gwords[g] = 0; grun[g] = 0; gstop[g] = 0;
            end else if (bus.gen_start[g]) begin
                gbusy[g] = 1'b1; gwords[g] = 0; grun[g] = 0; gstop[g] = 0;
            end else begin
                if (bus.gen_hdr_we[g]) begin
                    gwords[g]++;
                    if (gwords[g] == 20) grun[g] = run_len + g;
                end else if (gbusy[g] && gwords[g] >= 20 && !hold && grun[g] > 0) begin
                    grun[g]--;
                    if (grun[g] == 0) gbusy[g] = 1'b0;
                end
                if (gbusy[g] && bus.gen_stop[g]) begin
                    gstop[g]++;
                    if (gstop[g] >= 3) gbusy[g] = 1'b0;
                end
            end
            v[g] = !gbusy[g] && (cyc >= pre_until[g]);
        end
        bus.gen_stop_ack = v;
    end

    // Monitor: sample outputs mid-cycle and record loads, pulses and edges.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (bus.gen_start != '0) begin
                start_cnt++;
                start_cyc = cyc;
                if (bus.gen_start != 4'hF) start_err++;
                for (int g = 0; g < NG; g++) rec_n[g] = 0;
            end
            if (bus.gen_hdr_we != '0) begin
                if ($countones(bus.gen_hdr_we) != 1) we_err++;
                for (int g = 0; g < NG; g++) begin
                    if (bus.gen_hdr_we[g] && rec_n[g] < 20) begin
                        if (cyc != start_cyc + 1 + 21 * g + rec_n[g]) timing_err++;
                        if (rec_n[g] > 0 && bus.gen_nonce_size != rec_size[g]) size_err++;
                        rec_hdr[g][rec_n[g]] = bus.gen_hdr;
                        rec_size[g] = bus.gen_nonce_size;
                        rec_n[g]++;
                    end
                end
            end
            for (int g = 0; g < NG; g++) begin
                if (rec_n[g] == 20 && cyc == start_cyc + 21 + 21 * g &&
                    bus.gen_nonce_size != rec_size[g]) gap_err++;
            end
            if (bus.job_done) begin done_cnt++; done_cyc = cyc; end
            if (bus.job_aborted) begin abt_cnt++; abt_cyc = cyc; end
            if (bus.gen_stop != '0 && !prev_stop) stop_rise_cyc = cyc;
            if (bus.gen_stop == '0 && prev_stop) begin
                stop_fall_cnt++;
                if (!(&bus.gen_stop_ack)) stop_fall_bad++;
            end
            if ((&bus.gen_stop_ack) && !prev_all) ack_rise_cyc = cyc;
        end
        prev_stop = (bus.gen_stop != '0);
        prev_all  = &bus.gen_stop_ack;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_job(input logic [31:0] base, input logic [31:0] range, input bit gaps,
                            output bit ok);
        int i = 0;
        int guard = 0;
        bit v;
        bit r;
        hdr_ref[0] = base;
        for (int k = 1; k < 20; k++) hdr_ref[k] = $urandom;
        @(negedge clk); #1;
        bus.job_range = range;
        while (i < 20 && guard < 400) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.job_valid = v;
            bus.job_word  = hdr_ref[i];
            r = bus.job_ready;
            @(negedge clk); #1;
            if (v && r) i++;
            guard++;
        end
        bus.job_valid = 1'b0;
        ok = (i == 20);
    endtask

    task automatic wait_end(input int d0, input int a0, output bit to);
        int guard = 0;
        while (done_cnt == d0 && abt_cnt == a0 && guard < 3000) begin
            @(negedge clk); #1;
            guard++;
        end
        to = (guard >= 3000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (bus.job_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", bus.job_ready);
        end
        n_tests++;
        if ({bus.busy, bus.job_done, bus.job_aborted, bus.gen_start, bus.gen_stop,
             bus.gen_hdr_we} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bus.busy, bus.job_done,
                bus.job_aborted, bus.gen_start, bus.gen_stop, bus.gen_hdr_we});
        end
        n_tests++;
        if ({bus.gen_hdr, bus.gen_nonce_size, bus.job_count} !== 96'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0",
                {bus.gen_hdr, bus.gen_nonce_size, bus.job_count});
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (bus.job_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.job_ready);
        end
    endtask

    task automatic test_split(input string name, input logic [31:0] base,
                              input logic [31:0] range, input bit gaps);
        int d0 = done_cnt, a0 = abt_cnt, s0 = start_cnt, se0 = start_err;
        int e0 = timing_err + size_err + gap_err + we_err;
        logic [31:0] cnt0 = bus.job_count;
        logic [31:0] sl, eb, es;
        bit ok, to;
        int bad;
        run_len = $urandom_range(3, 40);
        for (int g = 0; g < NG; g++) pre_until[g] = cyc + $urandom_range(0, 30);
        send_job(base, range, gaps, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL %s_accept: got short want 20 words", name); end
        wait_end(d0, a0, to);
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (to) begin n_fail++; $display("FAIL %s_timeout: got no end want job_done", name); end
        n_tests++;
        if (done_cnt - d0 !== 1 || abt_cnt - a0 !== 0) begin
            n_fail++; $display("FAIL %s_pulses: got done=%0d abt=%0d want 1/0", name,
                done_cnt - d0, abt_cnt - a0);
        end
        n_tests++;
        if (bus.job_count !== cnt0 + 32'd1) begin
            n_fail++; $display("FAIL %s_count: got %0d want %0d", name, bus.job_count, cnt0 + 1);
        end
        n_tests++;
        if (start_cnt - s0 !== 1 || start_err !== se0) begin
            n_fail++; $display("FAIL %s_start: got %0d pulses want 1 all-ones", name,
                start_cnt - s0);
        end
        sl = range >> 2;
        for (int g = 0; g < NG; g++) begin
            es = (g == NG - 1) ? range - 32'(NG - 1) * sl : sl;
            eb = base + 32'(g) * sl;
            n_tests++;
            if (rec_hdr[g][0] !== eb) begin
                n_fail++; $display("FAIL %s_base%0d: got %h want %h", name, g, rec_hdr[g][0], eb);
            end
            n_tests++;
            if (rec_size[g] !== es) begin
                n_fail++; $display("FAIL %s_size%0d: got %h want %h", name, g, rec_size[g], es);
            end
            bad = 0;
            for (int w = 1; w < 20; w++) if (rec_hdr[g][w] !== hdr_ref[w]) bad++;
            n_tests++;
            if (rec_n[g] !== 20 || bad !== 0) begin
                n_fail++; $display("FAIL %s_words%0d: got n=%0d bad=%0d want 20/0", name, g,
                    rec_n[g], bad);
            end
        end
        n_tests++;
        if (timing_err + size_err + gap_err + we_err !== e0) begin
            n_fail++; $display("FAIL %s_load_timing: got %0d errors want 0", name,
                timing_err + size_err + gap_err + we_err - e0);
        end
        n_tests++;
        if (done_cyc !== ack_rise_cyc + 1) begin
            n_fail++; $display("FAIL %s_done_latency: got cyc %0d want %0d", name, done_cyc,
                ack_rise_cyc + 1);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy_end: got %b want 0", name, bus.busy);
        end
    endtask

    task automatic test_abort_load();
        int d0 = done_cnt, a0 = abt_cnt, s0 = start_cnt, f0 = stop_fall_cnt, fb0 = stop_fall_bad;
        logic [31:0] cnt0 = bus.job_count;
        int guard = 0;
        int loaded = 0;
        bit ok, to;
        hold = 1'b1;
        for (int g = 0; g < NG; g++) pre_until[g] = 0;
        send_job(32'h1234_0000, 32'h800, 1'b0, ok);
        while ((start_cnt == s0 || rec_n[1] < 6) && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        bus.abort = 1'b1;
        @(negedge clk); #1;
        bus.abort = 1'b0;
        wait_end(d0, a0, to);
        repeat (3) @(negedge clk);
        #1;
        hold = 1'b0;
        n_tests++;
        if (to || guard >= 300) begin
            n_fail++; $display("FAIL abort_load_timeout: got no end want job_aborted");
        end
        n_tests++;
        if (abt_cnt - a0 !== 1 || done_cnt - d0 !== 0) begin
            n_fail++; $display("FAIL abort_load_pulses: got abt=%0d done=%0d want 1/0",
                abt_cnt - a0, done_cnt - d0);
        end
        n_tests++;
        if (bus.job_count !== cnt0) begin
            n_fail++; $display("FAIL abort_load_count: got %0d want %0d", bus.job_count, cnt0);
        end
        for (int g = 0; g < NG; g++) if (rec_n[g] == 20) loaded++;
        n_tests++;
        if (loaded !== NG) begin
            n_fail++; $display("FAIL abort_load_complete: got %0d loaded want %0d", loaded, NG);
        end
        n_tests++;
        if (stop_rise_cyc !== start_cyc + 1 + 21 * NG) begin
            n_fail++; $display("FAIL abort_stop_rise: got cyc %0d want %0d", stop_rise_cyc,
                start_cyc + 1 + 21 * NG);
        end
        n_tests++;
        if (stop_fall_cnt - f0 !== 1 || stop_fall_bad !== fb0) begin
            n_fail++; $display("FAIL abort_stop_fall: got falls=%0d early=%0d want 1/0",
                stop_fall_cnt - f0, stop_fall_bad - fb0);
        end
        n_tests++;
        if (abt_cyc !== ack_rise_cyc + 1) begin
            n_fail++; $display("FAIL abort_latency: got cyc %0d want %0d", abt_cyc,
                ack_rise_cyc + 1);
        end
    endtask

    task automatic test_abort_capture();
        int d0 = done_cnt, a0 = abt_cnt, s0 = start_cnt;
        logic [31:0] cnt0 = bus.job_count;
        int i = 0;
        int guard = 0;
        bit r, to;
        @(negedge clk); #1;
        bus.job_range = 32'h5;
        while (i < 7 && guard < 100) begin
            bus.job_valid = 1'b1;
            bus.job_word  = $urandom;
            r = bus.job_ready;
            @(negedge clk); #1;
            if (r) i++;
            guard++;
        end
        bus.job_valid = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk); #1;
        bus.abort = 1'b0;
        wait_end(d0, a0, to);
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (to || abt_cnt - a0 !== 1 || done_cnt - d0 !== 0) begin
            n_fail++; $display("FAIL abort_cap_pulses: got abt=%0d done=%0d want 1/0",
                abt_cnt - a0, done_cnt - d0);
        end
        n_tests++;
        if (start_cnt !== s0 || bus.job_count !== cnt0) begin
            n_fail++; $display("FAIL abort_cap_side: got starts=%0d count=%0d want 0/%0d",
                start_cnt - s0, bus.job_count, cnt0);
        end
        n_tests++;
        if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_cap_idle: got ready=%b busy=%b want 1/0",
                bus.job_ready, bus.busy);
        end
    endtask

    task automatic test_zero_range();
        int d0 = done_cnt, a0 = abt_cnt, s0 = start_cnt;
        logic [31:0] cnt0 = bus.job_count;
        bit ok, to;
        send_job($urandom, 32'd0, 1'b0, ok);
        wait_end(d0, a0, to);
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (!ok || to || done_cnt - d0 !== 1 || abt_cnt !== a0) begin
            n_fail++; $display("FAIL zero_done: got done=%0d abt=%0d want 1/0",
                done_cnt - d0, abt_cnt - a0);
        end
        n_tests++;
        if (start_cnt !== s0) begin
            n_fail++; $display("FAIL zero_no_start: got %0d starts want 0", start_cnt - s0);
        end
        n_tests++;
        if (bus.job_count !== cnt0 + 32'd1) begin
            n_fail++; $display("FAIL zero_count: got %0d want %0d", bus.job_count, cnt0 + 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] b, r;
        for (int it = 0; it < 6; it++) begin
            b = $urandom;
            r = (it < 2) ? 32'($urandom_range(1, 7)) : $urandom;
            test_split($sformatf("rand%0d", it), b, r, 1'b1);
        end
    endtask

    task automatic test_reset_mid_load();
        int s0 = start_cnt;
        int guard = 0;
        bit ok;
        send_job(32'hABCD_0000, 32'h4000, 1'b0, ok);
        while ((start_cnt == s0 || rec_n[2] < 1) && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (bus.job_ready !== 1'b0 || guard >= 300) begin
            n_fail++; $display("FAIL rst_mid_ready: got %b want 0", bus.job_ready);
        end
        n_tests++;
        if ({bus.busy, bus.job_done, bus.job_aborted, bus.gen_start, bus.gen_stop,
             bus.gen_hdr_we} !== '0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0", {bus.busy, bus.job_done,
                bus.job_aborted, bus.gen_start, bus.gen_stop, bus.gen_hdr_we});
        end
        n_tests++;
        if ({bus.gen_hdr, bus.gen_nonce_size, bus.job_count} !== 96'd0) begin
            n_fail++; $display("FAIL rst_mid_data: got %h want 0",
                {bus.gen_hdr, bus.gen_nonce_size, bus.job_count});
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_release: got ready=%b busy=%b want 1/0",
                bus.job_ready, bus.busy);
        end
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.job_word  = 32'd0;
        bus.job_range = 32'd0;
        bus.abort     = 1'b0;
        for (int g = 0; g < NG; g++) begin
            pre_until[g] = 0;
            rec_n[g] = 0;
            rec_size[g] = 32'd0;
        end
        test_reset();
        test_split("basic", 32'h0000_0100, 32'h1000, 1'b0);
        test_split("remainder", 32'h0000_0100, 32'h1003, 1'b0);
        test_split("wrap", 32'hFFFF_FF00, 32'h400, 1'b0);
        test_abort_load();
        test_abort_capture();
        test_zero_range();
        test_random();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
